// File: rtl/btb_pkg.sv
// Shared types and constants for the branch target buffer.
// A tag slot wide enough for any legal index width keeps the entry struct fixed-size.
package btb_pkg;

    localparam int BTB_INDEX_BITS = 4;
    localparam int BTB_TAG_SLOT   = 30;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    typedef struct packed {
        logic                    valid;
        logic [BTB_TAG_SLOT-1:0] tag;
        logic [31:0]             target;
        logic [1:0]              ctr;
    } btb_entry_t;

    // Word offset is shifted left by two, so its top two bits never reach the sum.
    function automatic logic [31:0] btb_branch_target(input logic [31:0] pc,
                                                      input logic [29:0] offset);
        return pc + 32'd4 + {offset, 2'b00};
    endfunction

endpackage

// File: rtl/btb_sat_counter.sv
// Two-bit saturating direction counter, next-state only.
module btb_sat_counter
    import btb_pkg::*;
(
    input  logic [1:0] i_ctr,
    input  logic       i_taken,
    output logic [1:0] o_ctr_next
);

    always_comb begin
        o_ctr_next = i_ctr;
        if (i_taken) begin
            if (i_ctr != CTR_ST) begin
                o_ctr_next = i_ctr + 2'd1;
            end
        end else begin
            if (i_ctr != CTR_SNT) begin
                o_ctr_next = i_ctr - 2'd1;
            end
        end
    end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped BTB with 2-bit direction counters: combinational fetch lookup,
// decode-stage training with an internal target adder, registered mispredict pulse.
module btb_predictor
    import btb_pkg::*;
#(
    parameter int INDEX_BITS = BTB_INDEX_BITS
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] FetchPC,
    output logic        PredTaken,
    output logic [31:0] PredTarget,
    input  logic        UpdValid,
    input  logic [31:0] UpdPC,
    input  logic [31:0] UpdOffset,
    input  logic        UpdTaken,
    input  logic        UpdPredTaken,
    input  logic [31:0] UpdPredTarget,
    output logic        Mispredict
);

    localparam int TAG_BITS = 32 - 2 - INDEX_BITS;
    localparam int ENTRIES  = 1 << INDEX_BITS;

    btb_entry_t r_tbl [ENTRIES];
    logic       r_mispredict;

    logic [INDEX_BITS-1:0]   w_fetch_idx;
    logic [BTB_TAG_SLOT-1:0] w_fetch_tag;
    logic                    w_fetch_hit;

    logic [INDEX_BITS-1:0]   w_upd_idx;
    logic [BTB_TAG_SLOT-1:0] w_upd_tag;
    logic                    w_upd_hit;
    logic [31:0]             w_upd_target;
    logic [1:0]              w_ctr_next;
    logic                    w_mispredict_d;
    logic                    w_unused_bits;

    assign w_fetch_idx = FetchPC[INDEX_BITS+1:2];
    assign w_fetch_tag = BTB_TAG_SLOT'(FetchPC[31:INDEX_BITS+2]);
    assign w_fetch_hit = r_tbl[w_fetch_idx].valid && (r_tbl[w_fetch_idx].tag == w_fetch_tag);

    assign PredTaken  = w_fetch_hit && r_tbl[w_fetch_idx].ctr[1];
    assign PredTarget = PredTaken ? r_tbl[w_fetch_idx].target : (FetchPC + 32'd4);

    assign w_upd_idx    = UpdPC[INDEX_BITS+1:2];
    assign w_upd_tag    = BTB_TAG_SLOT'(UpdPC[31:INDEX_BITS+2]);
    assign w_upd_hit    = r_tbl[w_upd_idx].valid && (r_tbl[w_upd_idx].tag == w_upd_tag);
    assign w_upd_target = btb_branch_target(UpdPC, UpdOffset[29:0]);

    assign w_mispredict_d = UpdValid &&
                            ((UpdPredTaken != UpdTaken) ||
                             (UpdTaken && (UpdPredTarget != w_upd_target)));

    assign w_unused_bits = ^{FetchPC[1:0], UpdPC[1:0], UpdOffset[31:30]};

    btb_sat_counter u_ctr (
        .i_ctr      (r_tbl[w_upd_idx].ctr),
        .i_taken    (UpdTaken),
        .o_ctr_next (w_ctr_next)
    );

    // Lookup reads the flops directly, so a same-cycle update is not seen until next cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_tbl[i].valid  <= 1'b0;
                r_tbl[i].tag    <= '0;
                r_tbl[i].target <= '0;
                r_tbl[i].ctr    <= CTR_WNT;
            end
            r_mispredict <= 1'b0;
        end else begin
            r_mispredict <= w_mispredict_d;
            if (UpdValid) begin
                if (w_upd_hit) begin
                    r_tbl[w_upd_idx].ctr <= w_ctr_next;
                    if (UpdTaken) begin
                        r_tbl[w_upd_idx].target <= w_upd_target;
                    end
                end else if (UpdTaken) begin
                    r_tbl[w_upd_idx].valid  <= 1'b1;
                    r_tbl[w_upd_idx].tag    <= w_upd_tag;
                    r_tbl[w_upd_idx].target <= w_upd_target;
                    r_tbl[w_upd_idx].ctr    <= CTR_WT;
                end
            end
        end
    end

    assign Mispredict = r_mispredict;

endmodule

// File: tb/tb_btb_predictor.sv
// Directed-vector bench for btb_predictor with hand-computed expectations.
module tb_btb_predictor;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] FetchPC;
    logic        PredTaken;
    logic [31:0] PredTarget;
    logic        UpdValid;
    logic [31:0] UpdPC;
    logic [31:0] UpdOffset;
    logic        UpdTaken;
    logic        UpdPredTaken;
    logic [31:0] UpdPredTarget;
    logic        Mispredict;

    int n_checks = 0;
    int n_errors = 0;

    btb_predictor dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .FetchPC       (FetchPC),
        .PredTaken     (PredTaken),
        .PredTarget    (PredTarget),
        .UpdValid      (UpdValid),
        .UpdPC         (UpdPC),
        .UpdOffset     (UpdOffset),
        .UpdTaken      (UpdTaken),
        .UpdPredTaken  (UpdPredTaken),
        .UpdPredTarget (UpdPredTarget),
        .Mispredict    (Mispredict)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // One training cycle; returns with UpdValid low, just after the writing edge.
    task automatic upd(input logic [31:0] pc, input logic [31:0] off, input logic taken,
                       input logic ptaken, input logic [31:0] ptarget);
        UpdValid      = 1'b1;
        UpdPC         = pc;
        UpdOffset     = off;
        UpdTaken      = taken;
        UpdPredTaken  = ptaken;
        UpdPredTarget = ptarget;
        tick();
        UpdValid = 1'b0;
        #1;
    endtask

    task automatic look(input string tag, input logic [31:0] pc,
                        input logic exp_taken, input logic [31:0] exp_target);
        FetchPC = pc;
        #1;
        chk({tag, "_taken"}, 32'(PredTaken), 32'(exp_taken));
        chk({tag, "_target"}, PredTarget, exp_target);
    endtask

    initial begin
        Reset         = 1'b1;
        FetchPC       = 32'h0040_0000;
        UpdValid      = 1'b0;
        UpdPC         = '0;
        UpdOffset     = '0;
        UpdTaken      = 1'b0;
        UpdPredTaken  = 1'b0;
        UpdPredTarget = '0;
        tick();
        tick();
        Reset = 1'b0;
        #1;
        look("rst_lookup", 32'h0040_0000, 1'b0, 32'h0040_0004);
        chk("rst_mispredict", 32'(Mispredict), 32'd0);

        // Allocate: target = 0x00400014 - 0x10 = 0x00400004
        upd(32'h0040_0010, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0040_0014);
        chk("alloc_misp", 32'(Mispredict), 32'd1);
        look("alloc_look", 32'h0040_0010, 1'b1, 32'h0040_0004);
        tick();
        chk("misp_width", 32'(Mispredict), 32'd0);

        // Hysteresis: 10 -> 01 -> 00 -> 01 -> 10
        upd(32'h0040_0010, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'h0040_0004);
        chk("nt1_misp", 32'(Mispredict), 32'd1);
        look("nt1_look", 32'h0040_0010, 1'b0, 32'h0040_0014);
        upd(32'h0040_0010, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0040_0014);
        chk("nt2_misp", 32'(Mispredict), 32'd0);
        look("nt2_look", 32'h0040_0010, 1'b0, 32'h0040_0014);
        upd(32'h0040_0010, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0040_0014);
        chk("t1_misp", 32'(Mispredict), 32'd1);
        look("t1_look", 32'h0040_0010, 1'b0, 32'h0040_0014);
        upd(32'h0040_0010, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0040_0014);
        look("t2_look", 32'h0040_0010, 1'b1, 32'h0040_0004);

        // Correct prediction (10 -> 11), then right direction but wrong target
        upd(32'h0040_0010, 32'hFFFF_FFFC, 1'b1, 1'b1, 32'h0040_0004);
        chk("ok_misp", 32'(Mispredict), 32'd0);
        upd(32'h0040_0010, 32'hFFFF_FFFC, 1'b1, 1'b1, 32'h0040_0008);
        chk("tgt_misp", 32'(Mispredict), 32'd1);
        look("sat_look", 32'h0040_0010, 1'b1, 32'h0040_0004);

        // Alias at index 4: target = 0x00400054 + 0x20
        upd(32'h0040_0050, 32'h0000_0008, 1'b1, 1'b0, 32'h0040_0054);
        look("alias_old", 32'h0040_0010, 1'b0, 32'h0040_0014);
        look("alias_new", 32'h0040_0050, 1'b1, 32'h0040_0074);

        // Same-cycle update and lookup: read-old
        FetchPC       = 32'h0040_0020;
        UpdValid      = 1'b1;
        UpdPC         = 32'h0040_0020;
        UpdOffset     = 32'h0000_0000;
        UpdTaken      = 1'b1;
        UpdPredTaken  = 1'b0;
        UpdPredTarget = 32'h0040_0024;
        #1;
        chk("same_cyc_taken", 32'(PredTaken), 32'd0);
        chk("same_cyc_target", PredTarget, 32'h0040_0024);
        tick();
        UpdValid = 1'b0;
        #1;
        chk("after_cyc_taken", 32'(PredTaken), 32'd1);
        chk("after_cyc_target", PredTarget, 32'h0040_0024);
        chk("after_cyc_misp", 32'(Mispredict), 32'd1);

        // Address wrap on fetch and on target computation
        look("wrap_fetch", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);
        upd(32'hFFFF_FFF8, 32'h0000_0001, 1'b1, 1'b1, 32'h0000_0000);
        chk("wrap_misp", 32'(Mispredict), 32'd0);
        look("wrap_look", 32'hFFFF_FFF8, 1'b1, 32'h0000_0000);

        // Reset with a simultaneous update: update discarded, table cleared
        Reset         = 1'b1;
        UpdValid      = 1'b1;
        UpdPC         = 32'h0040_0030;
        UpdOffset     = 32'h0000_0010;
        UpdTaken      = 1'b1;
        UpdPredTaken  = 1'b0;
        UpdPredTarget = 32'h0040_0034;
        tick();
        Reset    = 1'b0;
        UpdValid = 1'b0;
        #1;
        chk("rst2_misp", 32'(Mispredict), 32'd0);
        look("rst2_a", 32'h0040_0010, 1'b0, 32'h0040_0014);
        look("rst2_b", 32'h0040_0050, 1'b0, 32'h0040_0054);
        look("rst2_c", 32'h0040_0020, 1'b0, 32'h0040_0024);
        look("rst2_d", 32'h0040_0030, 1'b0, 32'h0040_0034);
        tick();
        chk("rst2_misp_next", 32'(Mispredict), 32'd0);

        // Counter restarts at 01 after reset is not observable directly; a miss
        // with not-taken must leave the entry invalid.
        upd(32'h0040_0030, 32'h0000_0010, 1'b0, 1'b0, 32'h0040_0034);
        look("nt_miss", 32'h0040_0030, 1'b0, 32'h0040_0034);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
